adder_operand_loader: RTL and testbench
=======================================

Name: adder_operand_loader

Overview:
- Upstream feeder for the 32-bit carry increment adder.
- Accepts operands byte-serially over a valid/ready stream and assembles operand A, operand B and carry-in.
- Holds the assembled set stable on a, b, c0 with op_valid until the downstream stage acknowledges.
- Lets the combinational adder be driven from a narrow bus and gives the bench a registered, stable operand boundary.

Parameters:
- DATA_W, 32, operand width in bits; must be an integer multiple of BEAT_W.
- BEAT_W, 8, input beat width in bits.
- BEATS, DATA_W/BEAT_W, beats per operand (derived localparam, not overridable).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  BEAT_W  operand beat.
- in_cin  input  1  carry-in; sampled only with the last beat of B.
- in_valid  input  1  in_data/in_cin valid.
- in_ready  output  1  loader accepts a beat this cycle.
- a  output  DATA_W  assembled operand A.
- b  output  DATA_W  assembled operand B.
- c0  output  1  assembled carry-in.
- op_valid  output  1  a/b/c0 form a complete operand set.
- op_ready  input  1  downstream consumes the set.
- busy  output  1  a load is in progress (at least one beat of the current set accepted, set not yet presented).

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state=S_A, beat counter=0, a=0, b=0, c0=0, op_valid=0, busy=0. in_ready=0 while rst is high.
- Beat accept: a beat is accepted when in_valid && in_ready at a rising edge.
- Byte order: little-endian. Beat k of an operand writes bits [k*BEAT_W +: BEAT_W]. Unwritten bits keep their previous value until overwritten.
- FSM states (shared encoding):
  - S_A: in_ready=1. Each accepted beat writes a, counter+1. On accept with counter==BEATS-1: counter->0, go S_B.
  - S_B: in_ready=1. Each accepted beat writes b. On accept with counter==BEATS-1: c0<=in_cin, counter->0, op_valid<=1, go S_HOLD.
  - S_HOLD: in_ready=0, op_valid=1. a/b/c0 must not change. On op_ready: op_valid<=0, go S_A.
- No same-cycle re-accept: the first beat of the next set is accepted no earlier than the cycle after the op_valid&&op_ready handshake.
- in_valid low in S_A/S_B: state and counter hold; gaps of any length are legal.
- op_ready while op_valid=0: ignored.
- busy = (state==S_B) || (state==S_A && counter!=0).
- Latency: op_valid rises on the edge that accepts beat 2*BEATS. Minimum period is 2*BEATS+1 cycles per set (9 at defaults) with op_ready tied high.
- After handshake, a/b/c0 retain their last values (not cleared) until overwritten by the new load.
- Reset mid-load (any state): immediate return to reset values; partially loaded data is discarded.
- in_cin on non-final beats: don't-care, never sampled.
- Counter width: clog2(BEATS), minimum 1. Wrap beyond BEATS-1 is unreachable by construction.

Optional Feature:
- Macro: LOADER_PARITY_EN.
- Defined:
  - Adds port in_par (input, 1) carrying odd parity over in_data for each beat.
  - Adds port par_err (output, 1, reset 0).
  - Any accepted beat whose parity mismatches sets par_err (sticky). The beat is still stored and the flow is unchanged.
  - par_err clears on acceptance of the first beat of A of the next set, or on reset. If that first beat itself mismatches, par_err stays 1.
- Not defined: ports in_par and par_err do not exist; no parity logic.

Decomposition:
- Shared package/include adder_pkg: state encoding (S_A, S_B, S_HOLD), default DATA_W/BEAT_W constants, clog2 helper.
- One natural sub-module, operand_beat_reg: DATA_W register with lane-indexed write enable (beat index, data, we). Instantiated twice, for a and b.

Test Plan:
- Basic load: beats 78,56,34,12 then 01,00,00,00 with in_cin=1 on the last, op_ready=1 -> op_valid high on the edge accepting beat 8; a=0x12345678, b=0x00000001, c0=1; one-cycle pulse.
- Backpressure: same load, op_ready=0 for 5 cycles -> op_valid, a, b, c0 stable for all 5; in_ready=0 throughout; in_valid ignored; release -> in_ready=1 the next cycle.
- Bubbles: in_valid toggling 1,0,0,1,... -> only accepted beats advance the counter; a=0xDEADBEEF, b=0xFFFFFFFF assembled correctly; busy high from first beat until op_valid.
- Back-to-back: op_ready tied 1, three sets streamed -> new set every 9 cycles; values match each set; no beat lost or duplicated.
- Reset mid-load: assert rst after 5 beats -> outputs zero immediately; after release, a full fresh load assembles correctly with no leftover lanes.
- Parity (LOADER_PARITY_EN): corrupt parity on beat 3 -> par_err=1 from the next edge and held through the handshake; cleared on the first beat of the next good set.

Source files
------------

// File: rtl/adder_operand_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared definitions for the adder operand loader: FSM state
//                encoding, default operand/beat widths and a clog2 helper
//                that never returns less than 1.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_BEAT_W = 8;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Width needed to index n items; a single item still needs one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_operand_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : adder_operand_loader_if
//  Description : Bundles the byte-serial input stream and the assembled
//                operand output of the loader.
//                slave  : loader side (consumes beats, presents operands)
//                master : environment side (drives beats, consumes operands)
//                LOADER_PARITY_EN adds in_par / par_err.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adder_operand_loader_if
    import adder_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BEAT_W = DEF_BEAT_W
);
    logic [BEAT_W-1:0] in_data;
    logic              in_cin;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              c0;
    logic              op_valid;
    logic              op_ready;
    logic              busy;

`ifdef LOADER_PARITY_EN
    logic              in_par;
    logic              par_err;

    modport slave (
        input  in_data, in_cin, in_valid, op_ready, in_par,
        output in_ready, a, b, c0, op_valid, busy, par_err
    );
    modport master (
        output in_data, in_cin, in_valid, op_ready, in_par,
        input  in_ready, a, b, c0, op_valid, busy, par_err
    );
`else
    modport slave (
        input  in_data, in_cin, in_valid, op_ready,
        output in_ready, a, b, c0, op_valid, busy
    );
    modport master (
        output in_data, in_cin, in_valid, op_ready,
        input  in_ready, a, b, c0, op_valid, busy
    );
`endif

endinterface
`default_nettype wire

// File: rtl/adder_operand_loader_operand_beat_reg.sv
`default_nettype none
// ============================================================================
//  Module      : operand_beat_reg
//  Description : DATA_W register split into BEAT_W lanes; when we is high the
//                lane selected by idx takes data, all other lanes hold.
//  Ports       : clk, rst (async, active-high), we, idx, data, q
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_beat_reg #(
    parameter int DATA_W = 32,
    parameter int BEAT_W = 8,
    parameter int IDX_W  = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              we,
    input  wire logic [IDX_W-1:0]  idx,
    input  wire logic [BEAT_W-1:0] data,
    output logic      [DATA_W-1:0] q
);
    localparam int LANES = DATA_W / BEAT_W;

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            logic [BEAT_W-1:0] r_lane;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_lane <= '0;
                end else if (we && (idx == IDX_W'(g))) begin
                    r_lane <= data;
                end
            end

            assign q[g*BEAT_W +: BEAT_W] = r_lane;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/adder_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : adder_operand_loader
//  Description : Assembles operand A, operand B (little-endian, BEATS beats
//                each) and carry-in from a byte-serial valid/ready stream and
//                holds them stable with op_valid until op_ready.
//  Ports       : clk, rst (async, active-high),
//                bus (adder_operand_loader_if.slave): in_data, in_cin,
//                in_valid, in_ready, a, b, c0, op_valid, op_ready, busy
//                [+ in_par, par_err when LOADER_PARITY_EN is defined]
//  Options     : LOADER_PARITY_EN - odd-parity check per beat, sticky par_err
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_operand_loader
    import adder_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BEAT_W = DEF_BEAT_W
) (
    input  wire logic clk,
    input  wire logic rst,
    adder_operand_loader_if.slave bus
);
    localparam int BEATS = DATA_W / BEAT_W;
    localparam int CNT_W = clog2_min1(BEATS);

    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_c0;
    logic             w_ready;
    logic             w_we_a;
    logic             w_we_b;
    logic             w_c0_load;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_A;
            r_cnt   <= '0;
            r_c0    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_c0_load) begin
                r_c0 <= bus.in_cin;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready     = 1'b0;
        w_we_a      = 1'b0;
        w_we_b      = 1'b0;
        w_c0_load   = 1'b0;

        case (r_state)
            S_A: begin
                w_ready = 1'b1;
                if (bus.in_valid) begin
                    w_we_a = 1'b1;
                    if (r_cnt == c_last_beat) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_B;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
            end
            S_B: begin
                w_ready = 1'b1;
                if (bus.in_valid) begin
                    w_we_b = 1'b1;
                    if (r_cnt == c_last_beat) begin
                        w_c0_load   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
            end
            S_HOLD: begin
                // The handshake edge only leaves HOLD; the next set's first
                // beat can be accepted one cycle later at the earliest.
                if (bus.op_ready) begin
                    w_state_nxt = S_A;
                end
            end
            default: begin
                w_state_nxt = S_A;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand lane registers
    // ------------------------------------------------------------------
    operand_beat_reg #(
        .DATA_W (DATA_W),
        .BEAT_W (BEAT_W),
        .IDX_W  (CNT_W)
    ) u_reg_a (
        .clk  (clk),
        .rst  (rst),
        .we   (w_we_a),
        .idx  (r_cnt),
        .data (bus.in_data),
        .q    (w_a)
    );

    operand_beat_reg #(
        .DATA_W (DATA_W),
        .BEAT_W (BEAT_W),
        .IDX_W  (CNT_W)
    ) u_reg_b (
        .clk  (clk),
        .rst  (rst),
        .we   (w_we_b),
        .idx  (r_cnt),
        .data (bus.in_data),
        .q    (w_b)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // in_ready is forced low while rst is held, independent of the clock.
    assign bus.in_ready = w_ready & ~rst;
    assign bus.a        = w_a;
    assign bus.b        = w_b;
    assign bus.c0       = r_c0;
    assign bus.op_valid = (r_state == S_HOLD);
    assign bus.busy     = (r_state == S_B) || ((r_state == S_A) && (r_cnt != '0));

`ifdef LOADER_PARITY_EN
    logic r_par_err;
    logic w_par_bad;
    logic w_first_beat;

    // Odd parity: data bits plus in_par must contain an odd number of ones.
    assign w_par_bad    = ~(^{bus.in_data, bus.in_par});
    assign w_first_beat = (r_state == S_A) && (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else if (w_ready && bus.in_valid) begin
            if (w_first_beat) begin
                r_par_err <= w_par_bad;
            end else if (w_par_bad) begin
                r_par_err <= 1'b1;
            end
        end
    end

    assign bus.par_err = r_par_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_operand_loader
//  Description : Self-checking bench for adder_operand_loader. A set-level
//                model (beats taken so far, assembled words) predicts every
//                output each cycle; directed sequences add literal checks.
//                Covers LOADER_PARITY_EN when that macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adder_operand_loader;
    localparam int DW = 32;
    localparam int BW = 8;
    localparam int NB = DW / BW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_operand_loader_if #(.DATA_W(DW), .BEAT_W(BW)) bus ();

    adder_operand_loader #(.DATA_W(DW), .BEAT_W(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- set-level model ----------------
    int          m_nb  = 0;      // beats taken for the current set (2*NB = presented)
    logic [31:0] m_a   = '0;
    logic [31:0] m_b   = '0;
    logic        m_c   = 1'b0;
    logic        m_perr = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_nb = 0; m_a = '0; m_b = '0; m_c = 1'b0; m_perr = 1'b0;
        end else if (m_nb < 2*NB) begin
            if (bus.in_valid) begin
`ifdef LOADER_PARITY_EN
                if (m_nb == 0) m_perr = 1'b0;
                if ((^bus.in_data) == bus.in_par) m_perr = 1'b1;
`endif
                if (m_nb < NB) m_a[m_nb*BW +: BW] = bus.in_data;
                else           m_b[(m_nb-NB)*BW +: BW] = bus.in_data;
                if (m_nb == 2*NB-1) m_c = bus.in_cin;
                m_nb++;
            end
        end else if (bus.op_ready) begin
            m_nb = 0;
        end
    end

    // ---------------- per-cycle compare + set monitor ----------------
    int          cyc = 0;
    logic        prev_ov = 1'b0;
    int          rise_q[$];
    logic [31:0] seta_q[$];
    logic [31:0] setb_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", bus.in_ready, (m_nb < 2*NB) && !rst);
            chk("op_valid", bus.op_valid, m_nb == 2*NB);
            chk("busy",     bus.busy,     (m_nb > 0) && (m_nb < 2*NB));
            chk("a",        bus.a,        m_a);
            chk("b",        bus.b,        m_b);
            chk("c0",       bus.c0,       m_c);
`ifdef LOADER_PARITY_EN
            chk("par_err",  bus.par_err,  m_perr);
`endif
            if (bus.op_valid && !prev_ov) begin
                rise_q.push_back(cyc);
                seta_q.push_back(bus.a);
                setb_q.push_back(bus.b);
            end
            prev_ov = bus.op_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic cin, input logic bad);
        int  n;
        logic acc;
        bus.in_data  = d;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
`ifdef LOADER_PARITY_EN
        bus.in_par   = bad ? (^d) : ~(^d);
`else
        if (bad) bus.in_cin = cin;
`endif
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("beat_accepted_in_time", acc, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_set(input logic [31:0] av, input logic [31:0] bv, input logic cin, input int gap);
        for (int k = 0; k < NB; k++) begin
            send_beat(av[k*BW +: BW], 1'b0, 1'b0);
            if (gap > 0) idle(gap);
        end
        for (int k = 0; k < NB; k++) begin
            send_beat(bv[k*BW +: BW], (k == NB-1) ? cin : 1'b0, 1'b0);
            if (gap > 0 && k != NB-1) idle(gap);
        end
    endtask

    // ---------------- directed sequences ----------------
    initial begin
        int base;
        logic [31:0] pv;
        rst          = 1'b1;
        bus.in_data  = '0;
        bus.in_cin   = 1'b0;
        bus.in_valid = 1'b0;
        bus.op_ready = 1'b0;
`ifdef LOADER_PARITY_EN
        bus.in_par   = 1'b1;
`endif
        @(posedge clk); #1;
        chk_en = 1'b1;
        chk("reset_op_valid", bus.op_valid, 1'b0);
        chk("reset_in_ready_low", bus.in_ready, 1'b0);
        chk("reset_a", bus.a, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("reset_release_in_ready", bus.in_ready, 1'b1);
        chk("reset_busy", bus.busy, 1'b0);

        // Basic load with op_ready tied high: op_valid is a one-cycle pulse.
        bus.op_ready = 1'b1;
        send_set(32'h12345678, 32'h00000001, 1'b1, 0);
        chk("basic_op_valid", bus.op_valid, 1'b1);
        chk("basic_a", bus.a, 32'h12345678);
        chk("basic_b", bus.b, 32'h00000001);
        chk("basic_c0", bus.c0, 1'b1);
        @(posedge clk); #1;
        chk("basic_pulse_end", bus.op_valid, 1'b0);
        chk("basic_a_retained", bus.a, 32'h12345678);

        // Backpressure: set held for 5 cycles while in_valid is asserted.
        bus.op_ready = 1'b0;
        send_set(32'hCAFEF00D, 32'h80000001, 1'b0, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_a_stable", bus.a, 32'hCAFEF00D);
            chk("bp_b_stable", bus.b, 32'h80000001);
            chk("bp_in_ready_low", bus.in_ready, 1'b0);
            chk("bp_op_valid", bus.op_valid, 1'b1);
        end
        bus.in_valid = 1'b0;
        bus.op_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", bus.in_ready, 1'b1);
        chk("bp_release_op_valid", bus.op_valid, 1'b0);

        // Bubbles between beats.
        bus.op_ready = 1'b0;
        send_beat(8'hEF, 1'b0, 1'b0);
        chk("bub_busy_first", bus.busy, 1'b1);
        idle(2);
        chk("bub_busy_gap", bus.busy, 1'b1);
        send_beat(8'hBE, 1'b0, 1'b0); idle(2);
        send_beat(8'hAD, 1'b0, 1'b0); idle(2);
        send_beat(8'hDE, 1'b0, 1'b0); idle(2);
        for (int k = 0; k < NB; k++) begin
            send_beat(8'hFF, 1'b0, 1'b0);
            if (k != NB-1) idle(2);
        end
        chk("bub_a", bus.a, 32'hDEADBEEF);
        chk("bub_b", bus.b, 32'hFFFFFFFF);
        chk("bub_busy_done", bus.busy, 1'b0);
        bus.op_ready = 1'b1;
        @(posedge clk); #1;

        // Back-to-back sets with op_ready high: one set every 9 cycles.
        base = rise_q.size();
        send_set(32'h01234567, 32'h89ABCDEF, 1'b1, 0);
        send_set(32'hFFFFFFFF, 32'h00000001, 1'b1, 0);
        send_set(32'h00000000, 32'h7FFFFFFF, 1'b0, 0);
        @(posedge clk); #1;
        chk("b2b_set_count", rise_q.size() - base, 3);
        if (rise_q.size() >= base + 3) begin
            chk("b2b_period_1", rise_q[base+1] - rise_q[base], 9);
            chk("b2b_period_2", rise_q[base+2] - rise_q[base+1], 9);
            chk("b2b_a0", seta_q[base],   32'h01234567);
            chk("b2b_b0", setb_q[base],   32'h89ABCDEF);
            chk("b2b_a1", seta_q[base+1], 32'hFFFFFFFF);
            chk("b2b_b1", setb_q[base+1], 32'h00000001);
            chk("b2b_a2", seta_q[base+2], 32'h00000000);
            chk("b2b_b2", setb_q[base+2], 32'h7FFFFFFF);
        end

        // Reset after 5 beats.
        bus.op_ready = 1'b0;
        pv = 32'hAABBCCDD;
        for (int k = 0; k < NB; k++) send_beat(pv[k*BW +: BW], 1'b0, 1'b0);
        send_beat(8'h99, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mid_a", bus.a, 32'h0);
        chk("rst_mid_b", bus.b, 32'h0);
        chk("rst_mid_busy", bus.busy, 1'b0);
        chk("rst_mid_in_ready", bus.in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.op_ready = 1'b1;
        send_set(32'h01020304, 32'h0A0B0C0D, 1'b0, 1);
        chk("rst_fresh_a", bus.a, 32'h01020304);
        chk("rst_fresh_b", bus.b, 32'h0A0B0C0D);
        chk("rst_fresh_c0", bus.c0, 1'b0);
        @(posedge clk); #1;

`ifdef LOADER_PARITY_EN
        // Corrupt parity on the third beat of A.
        bus.op_ready = 1'b0;
        pv = 32'h44332211;
        for (int k = 0; k < NB; k++) begin
            send_beat(pv[k*BW +: BW], 1'b0, k == 2);
            if (k == 1) chk("par_clean_before", bus.par_err, 1'b0);
            if (k == 2) chk("par_err_set", bus.par_err, 1'b1);
        end
        for (int k = 0; k < NB; k++) send_beat(8'h10 + 8'(k), 1'b0, 1'b0);
        chk("par_err_held", bus.par_err, 1'b1);
        chk("par_a_stored", bus.a, 32'h44332211);
        bus.op_ready = 1'b1;
        @(posedge clk); #1;
        chk("par_err_after_hs", bus.par_err, 1'b1);
        send_beat(8'h77, 1'b0, 1'b0);
        chk("par_err_cleared", bus.par_err, 1'b0);
        for (int k = 1; k < NB; k++) send_beat(8'h77, 1'b0, 1'b0);
        for (int k = 0; k < NB; k++) send_beat(8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
`endif

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
